// File: rtl/biquad8_coeff_loader_if.sv
// ============================================================================
// biquad8_coeff_loader_if : Wishbone classic slave bus bundle for one biquad
// Rev 1.0
// ============================================================================
`default_nettype none

interface biquad8_coeff_loader_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [6:0]  wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

`default_nettype wire

// File: rtl/biquad8_coeff_loader.sv
// ============================================================================
// biquad8_coeff_loader : shadow/active coefficient banks with per-group pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module biquad8_coeff_loader #(
   parameter int COEFF_W = 18,
   parameter int NCOEFF  = 25
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   biquad8_coeff_loader_if.slave     wb,
   output logic [NCOEFF*COEFF_W-1:0] coeff_o,
   output logic                      coeff_update_o
);

   localparam int NGRP  = 7;
   localparam int IDX_W = $clog2(NCOEFF);
   localparam logic [2:0] LAST [NGRP] = '{3'd1, 3'd3, 3'd1, 3'd6, 3'd7, 3'd0, 3'd0};
   localparam int         BASE [NGRP] = '{0, 2, 6, 8, 15, 23, 24};

   logic                      ack_q, ack_d;
   logic                      upd_pend_q, upd_pend_d;
   logic                      update_q, update_d;
   logic                      seq_err_q, seq_err_d;
   logic [15:0]               cnt_q, cnt_d;
   logic [31:0]               dat_q, dat_d;
   logic [2:0]                ptr_q [NGRP];
   logic [2:0]                ptr_d [NGRP];
   logic signed [COEFF_W-1:0] shadow_q [NCOEFF];
   logic signed [COEFF_W-1:0] active_q [NCOEFF];

   logic             accept, grp_hit, wr_grp, upd_req, do_upd, any_ptr;
   logic [2:0]       grp;
   logic [2:0]       sel_ptr;
   logic [IDX_W-1:0] sel_idx;
   logic             unused_dat;

   assign unused_dat = ^wb.wb_dat_i[31:COEFF_W];
   assign accept     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;

   always_comb begin
      grp_hit = (wb.wb_adr_i[6:5] == 2'b00) && (wb.wb_adr_i[1:0] == 2'b00)
                && (wb.wb_adr_i[4:2] != 3'd0);
      grp     = wb.wb_adr_i[4:2] - 3'd1;
      sel_ptr = ptr_q[grp];
      sel_idx = IDX_W'(BASE[grp]) + IDX_W'(sel_ptr);
      wr_grp  = accept & wb.wb_we_i & grp_hit & (wb.wb_sel_i == 4'hF);
      upd_req = accept & wb.wb_we_i & (wb.wb_adr_i == 7'h00)
                & wb.wb_dat_i[0] & wb.wb_sel_i[0];
      // The bank swap happens on the edge that ends the ack cycle; no new
      // transaction can be accepted then, so it never collides with a write.
      do_upd  = upd_pend_q;

      any_ptr = 1'b0;
      for (int g = 0; g < NGRP; g++) begin
         any_ptr = any_ptr | (ptr_q[g] != 3'd0);
      end

      ack_d      = accept;
      upd_pend_d = upd_req;
      update_d   = do_upd;
      seq_err_d  = do_upd ? any_ptr : seq_err_q;
      cnt_d      = do_upd ? cnt_q + 16'd1 : cnt_q;

      for (int g = 0; g < NGRP; g++) begin
         ptr_d[g] = ptr_q[g];
         if (do_upd) begin
            ptr_d[g] = 3'd0;
         end else if (wr_grp && (grp == 3'(g))) begin
            ptr_d[g] = (ptr_q[g] == LAST[g]) ? 3'd0 : ptr_q[g] + 3'd1;
         end
      end

      dat_d = 32'd0;
      if (accept && !wb.wb_we_i) begin
         if (wb.wb_adr_i == 7'h00) begin
            dat_d = {seq_err_q, 15'd0, cnt_q};
         end else if (grp_hit) begin
            dat_d = 32'(shadow_q[sel_idx]);
         end else if (wb.wb_adr_i == 7'h20) begin
            dat_d = {20'd0, ptr_q[6][0], ptr_q[5][0], ptr_q[4], ptr_q[3],
                     ptr_q[2][0], ptr_q[1][1:0], ptr_q[0][0]};
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q      <= 1'b0;
         upd_pend_q <= 1'b0;
         update_q   <= 1'b0;
         seq_err_q  <= 1'b0;
         cnt_q      <= 16'd0;
         dat_q      <= 32'd0;
         for (int g = 0; g < NGRP; g++) begin
            ptr_q[g] <= 3'd0;
         end
         for (int k = 0; k < NCOEFF; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
      end else begin
         ack_q      <= ack_d;
         upd_pend_q <= upd_pend_d;
         update_q   <= update_d;
         seq_err_q  <= seq_err_d;
         cnt_q      <= cnt_d;
         dat_q      <= dat_d;
         ptr_q      <= ptr_d;
         if (wr_grp) begin
            shadow_q[sel_idx] <= wb.wb_dat_i[COEFF_W-1:0];
         end
         if (do_upd) begin
            active_q <= shadow_q;
         end
      end
   end

   assign wb.wb_ack_o    = ack_q;
   assign wb.wb_dat_o    = dat_q;
   assign coeff_update_o = update_q;

   for (genvar k = 0; k < NCOEFF; k++) begin : g_pack
      assign coeff_o[k*COEFF_W +: COEFF_W] = active_q[k];
   end

endmodule

`default_nettype wire

// File: tb/tb_biquad8_coeff_loader.sv
// ============================================================================
// tb_biquad8_coeff_loader : directed scoreboard bench for biquad8_coeff_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_biquad8_coeff_loader;
   localparam int COEFF_W = 18;
   localparam int NCOEFF  = 25;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NCOEFF*COEFF_W-1:0] coeff;
   logic                      coeff_update;

   biquad8_coeff_loader_if bus_if ();

   biquad8_coeff_loader #(.COEFF_W(COEFF_W), .NCOEFF(NCOEFF)) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .wb             (bus_if),
      .coeff_o        (coeff),
      .coeff_update_o (coeff_update)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          pulses = 0;
   int          ack_dbl = 0;
   logic        ack_prev = 1'b0;
   logic [31:0] exp_q [$];

   always @(negedge clk) begin
      if (coeff_update) pulses++;
      if (bus_if.wb_ack_o && ack_prev) ack_dbl++;
      ack_prev = bus_if.wb_ack_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] entry(input int k);
      return {14'd0, coeff[k*COEFF_W +: COEFF_W]};
   endfunction

   task automatic bus(input logic [6:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, output logic [31:0] rdata);
      logic got;
      got = 1'b0;
      bus_if.wb_cyc_i = 1'b1;
      bus_if.wb_stb_i = 1'b1;
      bus_if.wb_we_i  = we;
      bus_if.wb_adr_i = adr;
      bus_if.wb_sel_i = sel;
      bus_if.wb_dat_i = dat;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus_if.wb_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      rdata = bus_if.wb_dat_o;
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
      bus_if.wb_we_i  = 1'b0;
      if (!got) check("ack_timeout", 32'(got), 32'd1);
   endtask

   task automatic wr(input logic [6:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
      logic [31:0] d;
      bus(adr, dat, sel, 1'b1, d);
   endtask

   task automatic rd(input string tag, input logic [6:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      logic [31:0] e;
      exp_q.push_back(exp);
      bus(adr, 32'd0, 4'hF, 1'b0, d);
      e = exp_q.pop_front();
      check(tag, d, e);
   endtask

   task automatic update(input string tag);
      int p0;
      p0 = pulses;
      wr(7'h00, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check(tag, 32'(pulses - p0), 32'd1);
   endtask

   task automatic held(input logic [6:0] adr, input logic [31:0] dat, output int acks);
      acks = 0;
      bus_if.wb_cyc_i = 1'b1;
      bus_if.wb_stb_i = 1'b1;
      bus_if.wb_we_i  = 1'b1;
      bus_if.wb_adr_i = adr;
      bus_if.wb_sel_i = 4'hF;
      bus_if.wb_dat_i = dat;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus_if.wb_ack_o) acks++;
      end
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
      bus_if.wb_we_i  = 1'b0;
      @(posedge clk); #1;
   endtask

   int acks;
   int p0;
   logic [6:0] grp_adr [7] = '{7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h18, 7'h1C};
   int         grp_dep [7] = '{2, 4, 2, 7, 8, 1, 1};

   initial begin
      int v;
      rst = 1'b1;
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
      bus_if.wb_we_i  = 1'b0;
      bus_if.wb_adr_i = 7'h00;
      bus_if.wb_sel_i = 4'h0;
      bus_if.wb_dat_i = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(bus_if.wb_ack_o), 32'd0);
      check("rst_dat", bus_if.wb_dat_o, 32'd0);
      check("rst_upd", 32'(coeff_update), 32'd0);
      check("rst_coeff", 32'(|coeff), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      rd("rst_status", 7'h00, 32'd0);
      rd("rst_ptrs", 7'h20, 32'd0);

      // full load in map order, then update
      v = 1;
      for (int g = 0; g < 7; g++) begin
         for (int j = 0; j < grp_dep[g]; j++) begin
            wr(grp_adr[g], 32'(v));
            v++;
         end
      end
      rd("load_ptrs", 7'h20, 32'd0);
      update("load_pulse");
      for (int k = 0; k < NCOEFF; k++) check($sformatf("load_e%0d", k), entry(k), 32'(k + 1));
      rd("load_status", 7'h00, 32'd1);

      // pointer wrap on 0x04
      wr(7'h04, 32'd5);
      wr(7'h04, 32'd6);
      wr(7'h04, 32'd7);
      rd("wrap_ptrs", 7'h20, 32'd1);
      rd("wrap_rd04", 7'h04, 32'd6);
      check("wrap_pre_e0", entry(0), 32'd1);
      update("wrap_pulse");
      check("wrap_e0", entry(0), 32'd7);
      check("wrap_e1", entry(1), 32'd6);
      check("wrap_e2", entry(2), 32'd3);
      rd("wrap_status", 7'h00, 32'h8000_0002);

      update("clean_pulse");
      rd("clean_status", 7'h00, 32'd3);

      // held strobe
      held(7'h18, 32'h55, acks);
      check("held18_acks", 32'(acks), 32'd2);
      held(7'h10, 32'h77, acks);
      check("held10_acks", 32'(acks), 32'd2);
      rd("held_rd18", 7'h18, 32'h55);
      rd("held_ptrs", 7'h20, 32'h20);

      // ignored writes
      wr(7'h10, 32'h999, 4'h3);
      wr(7'h7C, 32'h123);
      rd("ign_ptrs", 7'h20, 32'h20);
      rd("ign_rd10", 7'h10, 32'd11);
      rd("ign_rd7c", 7'h7C, 32'd0);

      // negative value
      wr(7'h1C, 32'hFFFF_FFFE);
      rd("neg_rd1c", 7'h1C, 32'hFFFF_FFFE);
      check("neg_pre_e24", entry(24), 32'd25);
      update("neg_pulse");
      check("neg_e24", entry(24), 32'h3FFFE);
      check("neg_e23", entry(23), 32'h55);
      check("neg_e8", entry(8), 32'h77);
      check("neg_e9", entry(9), 32'h77);
      check("neg_e10", entry(10), 32'd11);
      rd("neg_status", 7'h00, 32'h8000_0004);
      rd("neg_ptrs", 7'h20, 32'd0);

      // reset mid-load
      for (int j = 0; j < 4; j++) wr(7'h14, 32'(j + 100));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rstmid_coeff", 32'(|coeff), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      update("rstmid_pulse");
      for (int k = 0; k < NCOEFF; k++) check($sformatf("rstmid_e%0d", k), entry(k), 32'd0);
      rd("rstmid_status", 7'h00, 32'd1);

      // update request killed by reset during its ack cycle
      p0 = pulses;
      bus_if.wb_cyc_i = 1'b1;
      bus_if.wb_stb_i = 1'b1;
      bus_if.wb_we_i  = 1'b1;
      bus_if.wb_adr_i = 7'h00;
      bus_if.wb_sel_i = 4'hF;
      bus_if.wb_dat_i = 32'd1;
      @(posedge clk); #1;
      rst = 1'b1;
      bus_if.wb_cyc_i = 1'b0;
      bus_if.wb_stb_i = 1'b0;
      bus_if.wb_we_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rstupd_ack", 32'(bus_if.wb_ack_o), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rstupd_pulse", 32'(pulses - p0), 32'd0);
      rd("rstupd_status", 7'h00, 32'd0);

      check("ack_double", 32'(ack_dbl), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
